// File: rtl/set_controller.sv
// Edit-and-commit controller for the clock's time/alarm setting modes.
// Preloads a shadow copy on mode entry, edits fields, and strobes a load on exit if changed.
module set_controller (
    input  logic       clock,
    input  logic       reset,
    input  logic       TIMESET_RUN,
    input  logic       ALARMSET_RUN,
    input  logic       SW_SEL,
    input  logic       SW_UP,
    input  logic       TICK,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    output logic [4:0] EDIT_HOUR,
    output logic [5:0] EDIT_MIN,
    output logic [5:0] EDIT_SEC,
    output logic [1:0] CURSOR,
    output logic       EDITING,
    output logic       BLINK,
    output logic       TIME_LOAD,
    output logic       ALARM_LOAD
);

    typedef enum logic [1:0] {IDLE, EDIT_T, EDIT_A} state_t;

    state_t     state, state_n;
    logic [4:0] hour_q, hour_n;
    logic [5:0] min_q, min_n, sec_q, sec_n;
    logic [1:0] cursor_q, cursor_n;
    logic       blink_q, blink_n;
    logic       dirty_q, dirty_n;
    logic       tload_q, tload_n;
    logic       aload_q, aload_n;
    logic       editing_q;
    logic       sel_prev, up_prev;
    logic       sel_edge, up_edge;

    // ">= limit-1" rather than "== limit-1" so out-of-range preloads also wrap to 0.
    function automatic logic [4:0] inc_hour(input logic [4:0] v);
        return (v >= 5'd23) ? '0 : v + 5'd1;
    endfunction

    function automatic logic [5:0] inc_60(input logic [5:0] v);
        return (v >= 6'd59) ? '0 : v + 6'd1;
    endfunction

    assign sel_edge = SW_SEL & ~sel_prev;
    assign up_edge  = SW_UP & ~up_prev;

    always_comb begin
        state_n  = state;
        hour_n   = hour_q;
        min_n    = min_q;
        sec_n    = sec_q;
        cursor_n = cursor_q;
        blink_n  = blink_q;
        dirty_n  = dirty_q;
        tload_n  = 1'b0;
        aload_n  = 1'b0;
        case (state)
            IDLE: begin
                blink_n = 1'b0;
                if (TIMESET_RUN) begin
                    state_n  = EDIT_T;
                    hour_n   = cur_hour;
                    min_n    = cur_min;
                    sec_n    = cur_sec;
                    cursor_n = '0;
                    dirty_n  = 1'b0;
                    blink_n  = 1'b1;
                end else if (ALARMSET_RUN) begin
                    state_n  = EDIT_A;
                    hour_n   = alarm_hour;
                    min_n    = alarm_min;
                    sec_n    = '0;
                    cursor_n = '0;
                    dirty_n  = 1'b0;
                    blink_n  = 1'b1;
                end
            end
            EDIT_T, EDIT_A: begin
                if ((state == EDIT_T && !TIMESET_RUN) || (state == EDIT_A && !ALARMSET_RUN)) begin
                    // Exit edge: any button edge here is dropped.
                    state_n = IDLE;
                    tload_n = (state == EDIT_T) && dirty_q;
                    aload_n = (state == EDIT_A) && dirty_q;
                    dirty_n = 1'b0;
                    blink_n = 1'b0;
                end else begin
                    if (up_edge) begin
                        dirty_n = 1'b1;
                        case (cursor_q)
                            2'd0:    hour_n = inc_hour(hour_q);
                            2'd1:    min_n  = inc_60(min_q);
                            default: if (state == EDIT_T) sec_n = inc_60(sec_q);
                        endcase
                    end
                    if (sel_edge) begin
                        if (state == EDIT_T)
                            cursor_n = (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
                        else
                            cursor_n = (cursor_q == 2'd0) ? 2'd1 : 2'd0;
                    end
                    if (up_edge || sel_edge)
                        blink_n = 1'b1;
                    else if (TICK)
                        blink_n = ~blink_q;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            hour_q    <= '0;
            min_q     <= '0;
            sec_q     <= '0;
            cursor_q  <= '0;
            blink_q   <= 1'b0;
            dirty_q   <= 1'b0;
            tload_q   <= 1'b0;
            aload_q   <= 1'b0;
            editing_q <= 1'b0;
            sel_prev  <= 1'b1;
            up_prev   <= 1'b1;
        end else begin
            state     <= state_n;
            hour_q    <= hour_n;
            min_q     <= min_n;
            sec_q     <= sec_n;
            cursor_q  <= cursor_n;
            blink_q   <= blink_n;
            dirty_q   <= dirty_n;
            tload_q   <= tload_n;
            aload_q   <= aload_n;
            editing_q <= (state_n != IDLE);
            sel_prev  <= SW_SEL;
            up_prev   <= SW_UP;
        end
    end

    assign EDIT_HOUR  = hour_q;
    assign EDIT_MIN   = min_q;
    assign EDIT_SEC   = sec_q;
    assign CURSOR     = cursor_q;
    assign EDITING    = editing_q;
    assign BLINK      = blink_q;
    assign TIME_LOAD  = tload_q;
    assign ALARM_LOAD = aload_q;

endmodule

// File: tb/tb_set_controller.sv
// Directed bench for set_controller; each task checks its own scenario inline.
module tb_set_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       TIMESET_RUN = 1'b0, ALARMSET_RUN = 1'b0;
    logic       SW_SEL = 1'b0, SW_UP = 1'b0, TICK = 1'b0;
    logic [4:0] cur_hour = '0, alarm_hour = '0;
    logic [5:0] cur_min = '0, cur_sec = '0, alarm_min = '0;
    logic [4:0] EDIT_HOUR;
    logic [5:0] EDIT_MIN, EDIT_SEC;
    logic [1:0] CURSOR;
    logic       EDITING, BLINK, TIME_LOAD, ALARM_LOAD;

    logic [16:0] edit_v, exp_e;
    logic [5:0]  ctl, exp_c;
    int          n_checks = 0;
    int          n_fail = 0;

    set_controller dut (
        .clock(clock), .reset(reset),
        .TIMESET_RUN(TIMESET_RUN), .ALARMSET_RUN(ALARMSET_RUN),
        .SW_SEL(SW_SEL), .SW_UP(SW_UP), .TICK(TICK),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .EDIT_HOUR(EDIT_HOUR), .EDIT_MIN(EDIT_MIN), .EDIT_SEC(EDIT_SEC),
        .CURSOR(CURSOR), .EDITING(EDITING), .BLINK(BLINK),
        .TIME_LOAD(TIME_LOAD), .ALARM_LOAD(ALARM_LOAD)
    );

    always #5 clock = ~clock;

    // Packed views: edit = {hour,min,sec}; ctl = {EDITING,BLINK,TIME_LOAD,ALARM_LOAD,CURSOR}.
    assign edit_v = {EDIT_HOUR, EDIT_MIN, EDIT_SEC};
    assign ctl    = {EDITING, BLINK, TIME_LOAD, ALARM_LOAD, CURSOR};

    // Inputs change and outputs are observed on the falling edge.
    task automatic step();
        @(negedge clock);
    endtask

    task automatic btn(input logic sel, input logic up);
        SW_SEL = sel;
        SW_UP  = up;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        exp_e = '0; exp_c = 6'b0_0_0_0_00;
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL reset_edit: got %h expected %h", edit_v, exp_e); end
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, exp_c); end
        reset = 1'b0;
        step();
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL idle_ctl: got %b expected %b", ctl, exp_c); end
    endtask

    task automatic test_time_commit();
        cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
        TIMESET_RUN = 1'b1;
        step();
        exp_e = {5'd12, 6'd34, 6'd56}; exp_c = 6'b1_1_0_0_00;
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL tc_preload: got %h expected %h", edit_v, exp_e); end
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL tc_entry_ctl: got %b expected %b", ctl, exp_c); end
        btn(1'b0, 1'b1);
        exp_e = {5'd13, 6'd34, 6'd56};
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL tc_up1: got %h expected %h", edit_v, exp_e); end
        btn(1'b0, 1'b0);
        btn(1'b0, 1'b1);
        btn(1'b0, 1'b0);
        exp_e = {5'd14, 6'd34, 6'd56};
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL tc_up2: got %h expected %h", edit_v, exp_e); end
        TIMESET_RUN = 1'b0;
        btn(1'b0, 1'b1);
        exp_c = 6'b0_0_1_0_00;
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL tc_strobe: got %b expected %b", ctl, exp_c); end
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL tc_exit_edit: got %h expected %h", edit_v, exp_e); end
        btn(1'b0, 1'b0);
        exp_c = 6'b0_0_0_0_00;
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL tc_strobe_end: got %b expected %b", ctl, exp_c); end
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL tc_hold: got %h expected %h", edit_v, exp_e); end
    endtask

    task automatic test_wrap();
        cur_hour = 5'd23; cur_min = 6'd59; cur_sec = 6'd59;
        TIMESET_RUN = 1'b1;
        step();
        btn(1'b0, 1'b1);
        exp_e = {5'd0, 6'd59, 6'd59};
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL wrap_hour: got %h expected %h", edit_v, exp_e); end
        btn(1'b0, 1'b0);
        btn(1'b1, 1'b0);
        exp_c = 6'b1_1_0_0_01;
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL wrap_cur1: got %b expected %b", ctl, exp_c); end
        btn(1'b0, 1'b0);
        btn(1'b0, 1'b1);
        exp_e = {5'd0, 6'd0, 6'd59};
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL wrap_min: got %h expected %h", edit_v, exp_e); end
        btn(1'b0, 1'b0);
        btn(1'b1, 1'b0);
        exp_c = 6'b1_1_0_0_10;
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL wrap_cur2: got %b expected %b", ctl, exp_c); end
        btn(1'b0, 1'b0);
        btn(1'b0, 1'b1);
        exp_e = '0;
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL wrap_sec: got %h expected %h", edit_v, exp_e); end
        btn(1'b0, 1'b0);
        btn(1'b1, 1'b0);
        exp_c = 6'b1_1_0_0_00;
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL wrap_cur0: got %b expected %b", ctl, exp_c); end
        btn(1'b0, 1'b0);
        TIMESET_RUN = 1'b0;
        step();
        step();
        cur_hour = 5'd30; cur_min = 6'd5; cur_sec = 6'd5;
        TIMESET_RUN = 1'b1;
        step();
        btn(1'b0, 1'b1);
        exp_e = {5'd0, 6'd5, 6'd5};
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL wrap_oor: got %h expected %h", edit_v, exp_e); end
        btn(1'b0, 1'b0);
        TIMESET_RUN = 1'b0;
        step();
        step();
    endtask

    task automatic test_alarm_cursor();
        cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
        alarm_hour = 5'd7; alarm_min = 6'd30;
        ALARMSET_RUN = 1'b1;
        step();
        exp_e = {5'd7, 6'd30, 6'd0}; exp_c = 6'b1_1_0_0_00;
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL al_preload: got %h expected %h", edit_v, exp_e); end
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL al_cur0: got %b expected %b", ctl, exp_c); end
        btn(1'b1, 1'b0);
        exp_c = 6'b1_1_0_0_01;
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL al_cur1: got %b expected %b", ctl, exp_c); end
        btn(1'b0, 1'b0);
        btn(1'b1, 1'b0);
        exp_c = 6'b1_1_0_0_00;
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL al_cur_wrap: got %b expected %b", ctl, exp_c); end
        btn(1'b0, 1'b0);
        btn(1'b1, 1'b0);
        exp_c = 6'b1_1_0_0_01;
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL al_cur1b: got %b expected %b", ctl, exp_c); end
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL al_sec_zero: got %h expected %h", edit_v, exp_e); end
        btn(1'b0, 1'b0);
        ALARMSET_RUN = 1'b0;
        step();
        n_checks++; if (ctl[5:2] !== 4'b0000) begin n_fail++; $display("FAIL al_no_load: got %b expected %b", ctl[5:2], 4'b0000); end
        step();
        n_checks++; if (ctl[5:2] !== 4'b0000) begin n_fail++; $display("FAIL al_no_load2: got %b expected %b", ctl[5:2], 4'b0000); end
    endtask

    task automatic test_simultaneous();
        cur_hour = 5'd5; cur_min = 6'd10; cur_sec = 6'd20;
        TIMESET_RUN = 1'b1;
        step();
        btn(1'b1, 1'b0);
        btn(1'b0, 1'b0);
        btn(1'b1, 1'b1);
        exp_e = {5'd5, 6'd11, 6'd20}; exp_c = 6'b1_1_0_0_10;
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL sim_min: got %h expected %h", edit_v, exp_e); end
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL sim_cursor: got %b expected %b", ctl, exp_c); end
        btn(1'b0, 1'b0);
        TIMESET_RUN = 1'b0;
        step();
        n_checks++; if (ctl[5:2] !== 4'b0010) begin n_fail++; $display("FAIL sim_load: got %b expected %b", ctl[5:2], 4'b0010); end
        step();
    endtask

    task automatic test_reset_mid_edit();
        cur_hour = 5'd8; cur_min = 6'd0; cur_sec = 6'd0;
        TIMESET_RUN = 1'b1;
        step();
        btn(1'b0, 1'b1);
        btn(1'b0, 1'b0);
        SW_UP = 1'b1;
        reset = 1'b1;
        step();
        exp_e = '0; exp_c = 6'b0_0_0_0_00;
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL rm_edit: got %h expected %h", edit_v, exp_e); end
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL rm_ctl: got %b expected %b", ctl, exp_c); end
        reset = 1'b0;
        step();
        exp_e = {5'd8, 6'd0, 6'd0}; exp_c = 6'b1_1_0_0_00;
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL rm_repreload: got %h expected %h", edit_v, exp_e); end
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL rm_reentry: got %b expected %b", ctl, exp_c); end
        step();
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL rm_held_btn: got %h expected %h", edit_v, exp_e); end
        SW_UP = 1'b0;
        step();
        TIMESET_RUN = 1'b0;
        step();
        exp_c = 6'b0_0_0_0_00;
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL rm_clean_exit: got %b expected %b", ctl, exp_c); end
        step();
    endtask

    task automatic test_blink_priority();
        cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
        alarm_hour = 5'd7; alarm_min = 6'd30;
        TIMESET_RUN = 1'b1;
        step();
        TICK = 1'b1;
        step();
        exp_c = 6'b1_0_0_0_00;
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL bl_tick1: got %b expected %b", ctl, exp_c); end
        TICK = 1'b0;
        step();
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL bl_hold: got %b expected %b", ctl, exp_c); end
        TICK = 1'b1;
        step();
        exp_c = 6'b1_1_0_0_00;
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL bl_tick2: got %b expected %b", ctl, exp_c); end
        step();
        exp_c = 6'b1_0_0_0_00;
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL bl_tick3: got %b expected %b", ctl, exp_c); end
        btn(1'b0, 1'b1);
        exp_c = 6'b1_1_0_0_00; exp_e = {5'd2, 6'd2, 6'd3};
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL bl_up_over_tick: got %b expected %b", ctl, exp_c); end
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL bl_up_edit: got %h expected %h", edit_v, exp_e); end
        TICK = 1'b0;
        btn(1'b0, 1'b0);
        TIMESET_RUN = 1'b0;
        step();
        exp_c = 6'b0_0_1_0_00;
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL bl_exit: got %b expected %b", ctl, exp_c); end
        step();
        TIMESET_RUN = 1'b1;
        ALARMSET_RUN = 1'b1;
        step();
        exp_e = {5'd1, 6'd2, 6'd3}; exp_c = 6'b1_1_0_0_00;
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL pri_time_preload: got %h expected %h", edit_v, exp_e); end
        btn(1'b1, 1'b0);
        btn(1'b0, 1'b0);
        btn(1'b1, 1'b0);
        exp_c = 6'b1_1_0_0_10;
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL pri_cursor2: got %b expected %b", ctl, exp_c); end
        btn(1'b0, 1'b0);
        TIMESET_RUN = 1'b0;
        ALARMSET_RUN = 1'b0;
        step();
        step();
    endtask

    task automatic test_back_to_back();
        cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
        alarm_hour = 5'd7; alarm_min = 6'd30;
        TIMESET_RUN = 1'b1;
        step();
        btn(1'b0, 1'b1);
        btn(1'b0, 1'b0);
        TIMESET_RUN = 1'b0;
        ALARMSET_RUN = 1'b1;
        step();
        exp_e = {5'd2, 6'd2, 6'd3};
        n_checks++; if (ctl[5:2] !== 4'b0010) begin n_fail++; $display("FAIL b2b_tload: got %b expected %b", ctl[5:2], 4'b0010); end
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL b2b_tedit: got %h expected %h", edit_v, exp_e); end
        step();
        exp_e = {5'd7, 6'd30, 6'd0}; exp_c = 6'b1_1_0_0_00;
        n_checks++; if (ctl !== exp_c) begin n_fail++; $display("FAIL b2b_aentry: got %b expected %b", ctl, exp_c); end
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL b2b_apreload: got %h expected %h", edit_v, exp_e); end
        btn(1'b0, 1'b1);
        btn(1'b0, 1'b0);
        ALARMSET_RUN = 1'b0;
        step();
        exp_e = {5'd8, 6'd30, 6'd0};
        n_checks++; if (ctl[5:2] !== 4'b0001) begin n_fail++; $display("FAIL b2b_aload: got %b expected %b", ctl[5:2], 4'b0001); end
        n_checks++; if (edit_v !== exp_e) begin n_fail++; $display("FAIL b2b_aedit: got %h expected %h", edit_v, exp_e); end
        step();
        n_checks++; if (ctl[5:2] !== 4'b0000) begin n_fail++; $display("FAIL b2b_aload_end: got %b expected %b", ctl[5:2], 4'b0000); end
    endtask

    initial begin
        test_reset();
        test_time_commit();
        test_wrap();
        test_alarm_cursor();
        test_simultaneous();
        test_reset_mid_edit();
        test_blink_priority();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
